writeback_stage: RTL

Registered successor to the register-file write-data selector. It selects one of NUM_SRC data sources or the fixed constant, applies optional sub-word load extension, and holds the result until the register file accepts it with a valid/ack handshake. It sits between the datapath source muxes or memory and the register-file write port of the multicycle core. It also flags misaligned halfword loads and counts committed writes.

---
 rtl/wb_pkg.sv | 16 +
 rtl/load_extender.sv | 30 +++
 rtl/writeback_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back stage.
package wb_pkg;

    localparam logic [2:0] EXT_NONE = 3'd0;
    localparam logic [2:0] EXT_BS   = 3'd1;
    localparam logic [2:0] EXT_BU   = 3'd2;
    localparam logic [2:0] EXT_HS   = 3'd3;
    localparam logic [2:0] EXT_HU   = 3'd4;

    typedef enum logic {WB_IDLE, WB_WRITE} wb_state_t;

    function automatic logic is_half_mode(input logic [2:0] mode);
        return (mode == EXT_HS) || (mode == EXT_HU);
    endfunction

endpackage

// File: rtl/load_extender.sv
// Sub-word load extension: picks a byte or halfword at the given offset and
// sign- or zero-extends it; unknown modes pass the word through.
module load_extender
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [2:0]        mode_i,
    input  logic [1:0]        off_i,
    output logic [DATA_W-1:0] word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(word_i >> {off_i, 3'b000});
        half_v = 16'(word_i >> {off_i[1], 4'b0000});
        word_o = word_i;
        case (mode_i)
            EXT_BS:  word_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
            EXT_BU:  word_o = {{(DATA_W-8){1'b0}}, byte_v};
            EXT_HS:  word_o = {{(DATA_W-16){half_v[15]}}, half_v};
            EXT_HU:  word_o = {{(DATA_W-16){1'b0}}, half_v};
            default: word_o = word_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Registered write-back stage: source select, load extension, and a
// valid/ack handshake toward the register-file write port.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned CONST_VAL = 227,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_valid_i,
    output logic                      wb_ready_o,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    input  logic [2:0]                ext_mode_i,
    input  logic [1:0]                byte_off_i,
    input  logic [ADDR_W-1:0]         dest_i,
    output logic                      rf_we_o,
    output logic [ADDR_W-1:0]         rf_addr_o,
    output logic [DATA_W-1:0]         rf_data_o,
    input  logic                      rf_ack_i,
    output logic                      align_err_o,
    output logic [CNT_W-1:0]          wb_count_o
);

    wb_state_t         state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              align_err_q, align_err_d;
    logic [CNT_W-1:0]  wb_count_q, wb_count_d;

    logic [DATA_W-1:0] sel_word;
    logic [DATA_W-1:0] ext_word;
    logic              accept;
    logic              misaligned;

    // Source mux: in-range sources, then the constant, otherwise zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (sel_i == SEL_W'(k)) sel_word = src_data_i[k*DATA_W +: DATA_W];
        end
        if (sel_i == SEL_W'(NUM_SRC)) sel_word = DATA_W'(CONST_VAL);
    end

    load_extender #(.DATA_W(DATA_W)) u_ext (
        .word_i (sel_word),
        .mode_i (ext_mode_i),
        .off_i  (byte_off_i),
        .word_o (ext_word)
    );

    assign wb_ready_o = (state_q == WB_IDLE) || ((state_q == WB_WRITE) && rf_ack_i);
    assign accept     = wb_valid_i && wb_ready_o;
    assign misaligned = is_half_mode(ext_mode_i) && byte_off_i[0];

    // Commit on ack first, then let a same-cycle request refill the stage.
    always_comb begin
        state_d     = state_q;
        rf_we_d     = rf_we_q;
        rf_addr_d   = rf_addr_q;
        rf_data_d   = rf_data_q;
        align_err_d = 1'b0;
        wb_count_d  = wb_count_q;

        if ((state_q == WB_WRITE) && rf_ack_i) begin
            state_d    = WB_IDLE;
            rf_we_d    = 1'b0;
            wb_count_d = wb_count_q + CNT_W'(1);
        end

        if (accept) begin
            if (misaligned) begin
                align_err_d = 1'b1;
            end else if (dest_i != '0) begin
                state_d   = WB_WRITE;
                rf_we_d   = 1'b1;
                rf_addr_d = dest_i;
                rf_data_d = ext_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WB_IDLE;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_data_q   <= '0;
            align_err_q <= 1'b0;
            wb_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rf_we_q     <= rf_we_d;
            rf_addr_q   <= rf_addr_d;
            rf_data_q   <= rf_data_d;
            align_err_q <= align_err_d;
            wb_count_q  <= wb_count_d;
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_addr_o   = rf_addr_q;
    assign rf_data_o   = rf_data_q;
    assign align_err_o = align_err_q;
    assign wb_count_o  = wb_count_q;

endmodule
